// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl: March C- sequencer driving an SRAM and an 8-bit comparator,
// counting mismatches and capturing the first failing address.
//   clk, rst_n                  clock, async active-low reset
//   start                       run request (accepted in IDLE or DONE)
//   mem_cs/we/addr/wdata        registered SRAM op, mem_rdata one cycle later
//   cmp_a, cmp_b, cmp_eq        comparator operands (read data, expected) and result
//   busy, done, pass            run status
//   fail_count                  saturating mismatch count
//   first_fail_valid/addr       address of the first mismatching read
module bist_march_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        cmp_a,
  output logic [7:0]        cmp_b,
  input  logic              cmp_eq,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_count,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_addr
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] elem;
  logic ph;
  logic [ADDR_W-1:0] addr;
  logic go, down, last_ph, last_addr, last_op, is_rd, run;
  logic chk_valid;
  logic [ADDR_W-1:0] chk_addr;
  logic cs_nx, we_nx, busy_nx, done_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [7:0] wdata_nx;
  // The internal state leads the registered pins by one cycle: the counters
  // hold the op that appears on the SRAM pins after the next edge.
  assign run       = state == RUN;
  assign go        = (state == IDLE || state == DONE) && start;
  assign down      = elem >= 3'd3;
  assign last_ph   = (elem == 3'd0 || elem == 3'd5) ? 1'b1 : ph;
  assign last_addr = down ? addr == '0 : addr == '1;
  assign last_op   = elem == 3'd5 && last_addr;
  assign is_rd     = elem != 3'd0 && !ph;
  assign cmp_a     = mem_rdata;
  assign pass      = done && fail_count == 8'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? RUN : state;
      RUN:        state_nx = last_op ? DRAIN : RUN;
      default:    state_nx = DONE;
    endcase
  end
  // Odd elements write D1 and read D0; even elements the opposite.
  always_comb begin
    cs_nx    = run;
    we_nx    = run && !is_rd;
    addr_nx  = run ? addr : '0;
    wdata_nx = (run && !is_rd && elem[0]) ? 8'hFF : 8'h00;
    busy_nx  = run || state == DRAIN;
    done_nx  = state == DONE && !start;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmp_b     <= 8'h00;
    end else begin
      mem_cs    <= cs_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      if (run && is_rd) cmp_b <= elem[0] ? 8'h00 : 8'hFF;
    end
  // Leaving element e, the next one starts at the top when it walks down (e >= 2).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      elem <= 3'd0;
      ph   <= 1'b0;
      addr <= '0;
    end else if (go) begin
      elem <= 3'd0;
      ph   <= 1'b0;
      addr <= '0;
    end else if (run) begin
      if (!last_ph) ph <= 1'b1;
      else begin
        ph <= 1'b0;
        if (last_addr) begin
          elem <= elem + 3'd1;
          addr <= elem >= 3'd2 ? '1 : '0;
        end else addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
      end
    end
  // The read on the pins is checked one cycle later, when its data returns.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chk_valid        <= 1'b0;
      chk_addr         <= '0;
      fail_count       <= 8'd0;
      first_fail_valid <= 1'b0;
      first_fail_addr  <= '0;
    end else begin
      chk_valid <= mem_cs && !mem_we;
      chk_addr  <= mem_addr;
      if (go) begin
        fail_count       <= 8'd0;
        first_fail_valid <= 1'b0;
        first_fail_addr  <= '0;
      end else if (chk_valid && !cmp_eq) begin
        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_addr  <= chk_addr;
        end
      end
    end
endmodule
